// File: rtl/cape_gpio_ctrl.sv
// APB-controlled 8-bit GPIO bank with per-pin synchronizer, debounce filter
// and edge-triggered level interrupt.
module cape_gpio_ctrl #(
   parameter int          DEB_CYCLES = 4,
   parameter logic [7:0]  RST_OE     = 8'h00
) (
   input  logic          PCLK,
   input  logic          RESET,
   input  logic          PSEL,
   input  logic          PENABLE,
   input  logic          PWRITE,
   input  logic [7:0]    PADDR,
   input  logic [31:0]   PWDATA,
   output logic [31:0]   PRDATA,
   output logic          PREADY,
   output logic          PSLVERR,
   output logic [18:11]  GPIO_OUT,
   output logic [18:11]  GPIO_OE,
   input  logic [18:11]  GPIO_IN,
   output logic          IRQ
);

   localparam logic [7:0] DEB_TC = 8'(DEB_CYCLES - 1);

   localparam logic [5:0] A_OUT  = 6'd0;
   localparam logic [5:0] A_OE   = 6'd1;
   localparam logic [5:0] A_IN   = 6'd2;
   localparam logic [5:0] A_EN   = 6'd3;
   localparam logic [5:0] A_STAT = 6'd4;
   localparam logic [5:0] A_TYPE = 6'd5;
   localparam logic [5:0] A_RAW  = 6'd6;

   logic [7:0] out_reg, oe_reg, irq_en, irq_stat, irq_type;
   logic [7:0] sync1, raw, filt;
   logic [7:0] cnt [8];
   logic [7:0] upd, stat_set, stat_clr;
   logic [5:0] reg_idx;
   logic       access, mapped, wr;
   logic       unused_bits;

   assign unused_bits = ^{PADDR[1:0], PWDATA[31:8]};

   // reset gates the access so a transfer overlapping reset has no effect
   assign access  = PSEL & PENABLE & ~RESET;
   assign reg_idx = PADDR[7:2];
   assign mapped  = (reg_idx <= A_RAW);
   assign wr      = access & PWRITE & mapped;

   assign PREADY   = 1'b1;
   assign PSLVERR  = access & ~mapped;
   assign GPIO_OUT = out_reg;
   assign GPIO_OE  = oe_reg;
   assign IRQ      = ~RESET & (|(irq_stat & irq_en));

   always_comb begin
      PRDATA = 32'h0;
      if (access) begin
         case (reg_idx)
            A_OUT:   PRDATA[7:0] = out_reg;
            A_OE:    PRDATA[7:0] = oe_reg;
            A_IN:    PRDATA[7:0] = filt;
            A_EN:    PRDATA[7:0] = irq_en;
            A_STAT:  PRDATA[7:0] = irq_stat;
            A_TYPE:  PRDATA[7:0] = irq_type;
            A_RAW:   PRDATA[7:0] = raw;
            default: PRDATA      = 32'h0;
         endcase
      end
   end

   // raw ^ type selects rising (type 0, new level 1) or falling (type 1, new level 0)
   always_comb begin
      upd = 8'h0;
      for (int i = 0; i < 8; i++)
         upd[i] = (raw[i] != filt[i]) && (cnt[i] == DEB_TC);
      stat_set = upd & (raw ^ irq_type);
      stat_clr = (wr && reg_idx == A_STAT) ? PWDATA[7:0] : 8'h0;
   end

   always_ff @(posedge PCLK) begin
      if (RESET) begin
         out_reg  <= 8'h0;
         oe_reg   <= RST_OE;
         irq_en   <= 8'h0;
         irq_stat <= 8'h0;
         irq_type <= 8'h0;
      end else begin
         if (wr && reg_idx == A_OUT)  out_reg  <= PWDATA[7:0];
         if (wr && reg_idx == A_OE)   oe_reg   <= PWDATA[7:0];
         if (wr && reg_idx == A_EN)   irq_en   <= PWDATA[7:0];
         if (wr && reg_idx == A_TYPE) irq_type <= PWDATA[7:0];
         irq_stat <= (irq_stat & ~stat_clr) | stat_set;
      end
   end

   always_ff @(posedge PCLK) begin
      if (RESET) begin
         sync1 <= 8'h0;
         raw   <= 8'h0;
         filt  <= 8'h0;
         for (int i = 0; i < 8; i++) cnt[i] <= 8'h0;
      end else begin
         sync1 <= GPIO_IN;
         raw   <= sync1;
         for (int i = 0; i < 8; i++) begin
            if (raw[i] == filt[i]) begin
               cnt[i] <= 8'h0;
            end else if (upd[i]) begin
               filt[i] <= raw[i];
               cnt[i]  <= 8'h0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cape_gpio_ctrl.sv
// Self-checking bench for cape_gpio_ctrl: register vector table plus
// sequences for debounce latency, glitch rejection, W1C/set collision and reset.
module tb_cape_gpio_ctrl;

   logic         PCLK = 1'b0;
   logic         RESET;
   logic         PSEL, PENABLE, PWRITE;
   logic [7:0]   PADDR;
   logic [31:0]  PWDATA;
   logic [31:0]  PRDATA;
   logic         PREADY, PSLVERR;
   logic [18:11] GPIO_OUT, GPIO_OE, GPIO_IN;
   logic         IRQ;

   int checks = 0;
   int errors = 0;
   logic irq_at_acc;

   cape_gpio_ctrl #(.DEB_CYCLES(4), .RST_OE(8'h00)) dut (
      .PCLK(PCLK), .RESET(RESET), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .GPIO_OUT(GPIO_OUT),
      .GPIO_OE(GPIO_OE), .GPIO_IN(GPIO_IN), .IRQ(IRQ)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      string       name;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      bit          chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t vecs[15];

   task automatic sb_push(input string name, input logic [31:0] exp);
      sb_t e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] act);
      sb_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got=%h", act);
      end else begin
         e = sb_q.pop_front();
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", e.name, act, e.exp);
         end
      end
   endtask

   // called just after a rising edge; the write lands on the second edge
   task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      @(negedge PCLK);
      rd = PRDATA; err = PSLVERR; irq_at_acc = IRQ;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic        err;
      sb_push(name, exp);
      sb_push({name, "_err"}, 32'h0);
      apb(1'b0, addr, 32'h0, rd, err);
      sb_check(rd);
      sb_check({31'h0, err});
   endtask

   task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      logic        err;
      apb(1'b1, addr, wd, rd, err);
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;

      vecs[0]  = '{"rd_out_rst",  1'b0, 8'h00, 32'h0,  1'b1, 32'h00, 1'b0};
      vecs[1]  = '{"rd_oe_rst",   1'b0, 8'h04, 32'h0,  1'b1, 32'h00, 1'b0};
      vecs[2]  = '{"wr_oe",       1'b1, 8'h04, 32'hFF, 1'b0, 32'h00, 1'b0};
      vecs[3]  = '{"wr_out",      1'b1, 8'h00, 32'hA5, 1'b0, 32'h00, 1'b0};
      vecs[4]  = '{"rd_oe",       1'b0, 8'h04, 32'h0,  1'b1, 32'hFF, 1'b0};
      vecs[5]  = '{"rd_out",      1'b0, 8'h00, 32'h0,  1'b1, 32'hA5, 1'b0};
      vecs[6]  = '{"rd_unmapped", 1'b0, 8'h1C, 32'h0,  1'b1, 32'h00, 1'b1};
      vecs[7]  = '{"wr_in_ro",    1'b1, 8'h08, 32'hFF, 1'b0, 32'h00, 1'b0};
      vecs[8]  = '{"rd_in",       1'b0, 8'h08, 32'h0,  1'b1, 32'h00, 1'b0};
      vecs[9]  = '{"wr_type",     1'b1, 8'h14, 32'h02, 1'b0, 32'h00, 1'b0};
      vecs[10] = '{"rd_type",     1'b0, 8'h14, 32'h0,  1'b1, 32'h02, 1'b0};
      vecs[11] = '{"rd_en",       1'b0, 8'h0C, 32'h0,  1'b1, 32'h00, 1'b0};
      vecs[12] = '{"wr_unmapped", 1'b1, 8'h40, 32'h55, 1'b0, 32'h00, 1'b1};
      vecs[13] = '{"rd_raw",      1'b0, 8'h18, 32'h0,  1'b1, 32'h00, 1'b0};
      vecs[14] = '{"rd_top",      1'b0, 8'hFF, 32'h0,  1'b1, 32'h00, 1'b1};

      RESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 8'h0; PWDATA = 32'h0; GPIO_IN = 8'h0;
      repeat (3) @(posedge PCLK);
      #1 RESET = 1'b0;

      @(negedge PCLK);
      sb_push("rst_irq", 32'h0);        sb_check({31'h0, IRQ});
      sb_push("rst_oe_pad", 32'h0);     sb_check({24'h0, GPIO_OE});
      sb_push("rst_out_pad", 32'h0);    sb_check({24'h0, GPIO_OUT});
      sb_push("pready", 32'h1);         sb_check({31'h0, PREADY});
      @(posedge PCLK); #1;

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].chk_rd) sb_push(vecs[i].name, vecs[i].exp_rd);
         sb_push({vecs[i].name, "_err"}, {31'h0, vecs[i].exp_err});
         apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
         if (vecs[i].chk_rd) sb_check(rd);
         sb_check({31'h0, err});
      end
      sb_push("pad_oe", 32'hFF);  sb_check({24'h0, GPIO_OE});
      sb_push("pad_out", 32'hA5); sb_check({24'h0, GPIO_OUT});

      // pad write is visible the cycle after the access, not during it
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h3C;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      sb_push("pad_out_acc", 32'hA5);
      @(negedge PCLK); sb_check({24'h0, GPIO_OUT});
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      sb_push("pad_out_next", 32'h3C); sb_check({24'h0, GPIO_OUT});

      // debounce latency on pin 11 observed through IRQ
      wr_reg(8'h0C, 32'h01);
      GPIO_IN[11] = 1'b1;
      sb_push("lat_irq_5", 32'h0);
      sb_push("lat_irq_6", 32'h1);
      repeat (5) @(posedge PCLK);
      @(negedge PCLK); sb_check({31'h0, IRQ});
      @(posedge PCLK);
      @(negedge PCLK); sb_check({31'h0, IRQ});
      @(posedge PCLK); #1;
      rd_chk("in_after_rise", 8'h08, 32'h01);
      rd_chk("stat_after_rise", 8'h10, 32'h01);

      sb_push("w1c_irq_acc", 32'h1);
      sb_push("w1c_irq_next", 32'h0);
      wr_reg(8'h10, 32'h01);
      sb_check({31'h0, irq_at_acc});
      sb_check({31'h0, IRQ});

      // 3-clock glitch on pin 12 must be rejected
      GPIO_IN[12] = 1'b1;
      repeat (3) @(posedge PCLK);
      #1 GPIO_IN[12] = 1'b0;
      repeat (12) @(posedge PCLK);
      #1;
      rd_chk("in_glitch", 8'h08, 32'h01);
      rd_chk("stat_glitch", 8'h10, 32'h00);

      // clean rise on pin 12 (falling-edge type: no event)
      GPIO_IN[12] = 1'b1;
      repeat (10) @(posedge PCLK);
      #1;
      rd_chk("in_pin12_hi", 8'h08, 32'h03);
      rd_chk("stat_no_rise", 8'h10, 32'h00);

      // falling edge on pin 12 lands on the same edge as a W1C of bit1
      GPIO_IN[12] = 1'b0;
      repeat (4) @(posedge PCLK);
      #1 wr_reg(8'h10, 32'h02);
      rd_chk("stat_set_wins", 8'h10, 32'h02);
      rd_chk("in_pin12_lo", 8'h08, 32'h01);
      wr_reg(8'h0C, 32'h03);
      sb_push("irq_bit1", 32'h1); sb_check({31'h0, IRQ});

      // reset pulse while pin 13 is two counts into its debounce
      GPIO_IN[13] = 1'b1;
      repeat (4) @(posedge PCLK);
      #1 RESET = 1'b1;
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h1C;
      @(negedge PCLK);
      sb_push("rstmid_irq", 32'h0);    sb_check({31'h0, IRQ});
      sb_push("rstmid_slverr", 32'h0); sb_check({31'h0, PSLVERR});
      sb_push("rstmid_prdata", 32'h0); sb_check(PRDATA);
      @(posedge PCLK); #1;
      RESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      sb_push("post_rst_irq_5", 32'h0);
      sb_push("post_rst_irq_6", 32'h1);
      wr_reg(8'h0C, 32'h04);
      repeat (3) @(posedge PCLK);
      @(negedge PCLK); sb_check({31'h0, IRQ});
      @(posedge PCLK);
      @(negedge PCLK); sb_check({31'h0, IRQ});
      @(posedge PCLK); #1;
      sb_push("post_rst_oe_pad", 32'h0); sb_check({24'h0, GPIO_OE});
      rd_chk("post_rst_out", 8'h00, 32'h00);
      rd_chk("post_rst_type", 8'h14, 32'h00);
      rd_chk("post_rst_in", 8'h08, 32'h05);
      rd_chk("post_rst_stat", 8'h10, 32'h05);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/cape_gpio_ctrl.md
CAPE_GPIO_CTRL -- requirements
Module: cape_gpio_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable clocks required before a filtered input changes; legal range 1..255.
REQ-002 Parameter RST_OE, default 8'h00: reset value of the output-enable register.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 PCLK  in  1  sole clock; all state changes on the rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 PSEL  in  1  APB select.
REQ-007 PENABLE  in  1  APB access phase.
REQ-008 PWRITE  in  1  APB write (1) / read (0).
REQ-009 PADDR  in  8  APB byte address; bits [1:0] ignored.
REQ-010 PWDATA  in  32  APB write data; bits [7:0] used.
REQ-011 PRDATA  out  32  APB read data; bits [31:8] always 0.
REQ-012 PREADY  out  1  tied 1; zero wait states.
REQ-013 PSLVERR  out  1  error flag for unmapped addresses.
REQ-014 GPIO_OUT  out  [18:11]  pad drive values; register bit i drives index 11+i.
REQ-015 GPIO_OE  out  [18:11]  pad output enables; 1 = drive.
REQ-016 GPIO_IN  in  [18:11]  raw, asynchronous pad input values.
REQ-017 IRQ  out  1  level interrupt.

Function
REQ-018 An APB transfer completes in the cycle in which PSEL=1 and PENABLE=1; writes take effect at the end of that cycle.
REQ-019 Register map: 0x00 OUT (rw), 0x04 OE (rw), 0x08 IN (ro, filtered), 0x0C IRQ_EN (rw), 0x10 IRQ_STAT (read / write-1-to-clear), 0x14 IRQ_TYPE (rw; 0 = rising edge, 1 = falling edge), 0x18 RAW (ro, synchronized but unfiltered).
REQ-020 An access to any other address in 0x00..0xFF: PSLVERR=1 in the access cycle, no state change, PRDATA=0.
REQ-021 A write to IN or RAW: no state change, PSLVERR=0.
REQ-022 PRDATA is combinational from the current register values during the access cycle; PRDATA=0 when the access condition is false.
REQ-023 GPIO_OUT and GPIO_OE are driven directly from the OUT and OE registers; a write is visible on the pads the cycle after the access.
REQ-024 Each GPIO_IN bit passes through a 2-flop synchronizer; RAW holds the second-stage output.
REQ-025 Debounce, per bit, with counter cnt (8 bits) and filtered value filt:
  - RAW == filt: cnt <= 0.
  - RAW != filt and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - RAW != filt and cnt == DEB_CYCLES-1: filt <= RAW, cnt <= 0.
  - A glitch shorter than DEB_CYCLES clocks never changes filt.
REQ-026 Latency: a clean pad step is visible in IN exactly 2+DEB_CYCLES clocks after the first PCLK edge that samples the new level.
REQ-027 Edge event: IRQ_STAT[i] is set in the cycle in which filt[i] updates with a direction matching IRQ_TYPE[i]; IRQ_STAT bits are set regardless of IRQ_EN.
REQ-028 A W1C write clears the addressed IRQ_STAT bits; if a set event and a clear of the same bit coincide, set wins.
REQ-029 IRQ = OR over (IRQ_STAT & IRQ_EN), combinational from registers; IRQ deasserts the cycle after the last enabled bit is cleared.
REQ-030 Changing IRQ_TYPE does not itself set IRQ_STAT; only subsequent filt transitions are evaluated.
REQ-031 Bits with OE=1 still sample, filter and raise events from their pads (loop-back allowed).

Reset
REQ-032 While RESET=1 at a PCLK edge:
  - OUT=0, OE=RST_OE, IRQ_EN=0, IRQ_STAT=0, IRQ_TYPE=0.
  - Synchronizer flops=0, filt=0, cnt=0.
REQ-033 During reset: IRQ=0, PSLVERR=0, PRDATA=0; APB writes are ignored.
REQ-034 A reset asserted mid-debounce discards the pending count; after reset the first transition needs a full 2+DEB_CYCLES clocks.

Verification
REQ-035 Write 0x04=0xFF, then 0x00=0xA5 -> GPIO_OE=8'hFF and GPIO_OUT=8'hA5 one cycle after the access; reads return 0xFF and 0xA5.
REQ-036 DEB_CYCLES=4, GPIO_IN[11] steps 0->1 -> IN bit0=1 exactly 6 clocks later; a 3-clock pulse on GPIO_IN[12] -> IN and IRQ_STAT unchanged.
REQ-037 IRQ_EN=0x01, IRQ_TYPE=0, rising edge on pin 11 -> IRQ_STAT=0x01 and IRQ=1; write 0x10=0x01 -> IRQ=0 next cycle.
REQ-038 IRQ_TYPE=0x02, falling edge on pin 12 coinciding with a W1C of bit1 -> IRQ_STAT bit1 remains 1.
REQ-039 Read 0x1C -> PSLVERR=1, PRDATA=0; write 0x08=0xFF -> IN unchanged, PSLVERR=0.
REQ-040 RESET pulsed while pin 13 is mid-debounce (cnt=2) -> all registers at reset values, IRQ=0, and the level seen after reset takes the full 6 clocks to appear in IN.
